// File: rtl/ram_fifo_ctrl_if.sv
// Bus bundle between ram_fifo_ctrl and its surroundings: write stream, FWFT read stream,
// fill level and the two dual_port_ram ports. almost_full exists only with RAM_FIFO_AFULL_EN.
interface ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [ADDR_WIDTH+1:0] count;
    logic                  ram_we1;
    logic [ADDR_WIDTH-1:0] ram_addr1;
    logic [DATA_WIDTH-1:0] ram_din1;
    logic                  ram_we2;
    logic [ADDR_WIDTH-1:0] ram_addr2;
    logic [DATA_WIDTH-1:0] ram_dout2;
`ifdef RAM_FIFO_AFULL_EN
    logic                  almost_full;
`endif

    // master: producer/consumer/RAM side; slave: the controller
    modport master (
        output s_valid, s_data, m_ready, ram_dout2,
        input  s_ready, m_valid, m_data, count,
        input  ram_we1, ram_addr1, ram_din1, ram_we2, ram_addr2
`ifdef RAM_FIFO_AFULL_EN
        , input almost_full
`endif
    );

    modport slave (
        input  s_valid, s_data, m_ready, ram_dout2,
        output s_ready, m_valid, m_data, count,
        output ram_we1, ram_addr1, ram_din1, ram_we2, ram_addr2
`ifdef RAM_FIFO_AFULL_EN
        , output almost_full
`endif
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FWFT FIFO controller around an external dual_port_ram (port 1 writes, port 2 reads) with a
// 2-entry skid absorbing the RAM read latency. Optional RAM_FIFO_AFULL_EN adds almost_full.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
`ifdef RAM_FIFO_AFULL_EN
    ,
    parameter int AFULL_THRESH = (2 ** ADDR_WIDTH) - 2
`endif
) (
    input  logic             clk,
    input  logic             rst,
    ram_fifo_ctrl_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int CW    = ADDR_WIDTH + 2;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [DATA_WIDTH-1:0] skid_q [2];
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [1:0]            skid_cnt_q, skid_cnt_d;

    logic [PW-1:0] ram_cnt;
    logic [2:0]    occ_after_pop;
    logic          push, pop, issue, m_valid;

    assign ram_cnt = wr_ptr_q - rd_ptr_q;
    assign m_valid = (skid_cnt_q != 2'd0);
    assign pop     = m_valid && bus.m_ready;
    assign push    = bus.s_valid && bus.s_ready;

    // A new read may only be issued if its data is guaranteed a free skid slot on return
    assign occ_after_pop = 3'(skid_cnt_q) + 3'(rd_pend_q) - 3'(pop);
    assign issue         = (ram_cnt != '0) && (occ_after_pop < 3'd2);

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(issue);
        rd_pend_d  = issue;
        head_d     = head_q ^ pop;
        tail_d     = tail_q ^ rd_pend_q;
        skid_cnt_d = skid_cnt_q + 2'(rd_pend_q) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_pend_q  <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            skid_cnt_q <= 2'd0;
            skid_q[0]  <= '0;
            skid_q[1]  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_pend_q  <= rd_pend_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            skid_cnt_q <= skid_cnt_d;
            if (rd_pend_q) skid_q[tail_q] <= bus.ram_dout2;
        end
    end

    assign bus.s_ready   = (ram_cnt != PW'(DEPTH));
    assign bus.ram_we1   = push;
    assign bus.ram_addr1 = wr_ptr_q[ADDR_WIDTH-1:0];
    assign bus.ram_din1  = bus.s_data;
    assign bus.ram_we2   = 1'b0;
    assign bus.ram_addr2 = rd_ptr_q[ADDR_WIDTH-1:0];
    assign bus.m_valid   = m_valid;
    // When empty, the slot behind head is the most recently popped word, so m_data holds
    assign bus.m_data    = m_valid ? skid_q[head_q] : skid_q[~head_q];
    assign bus.count     = CW'(ram_cnt) + CW'(rd_pend_q) + CW'(skid_cnt_q);

`ifdef RAM_FIFO_AFULL_EN
    logic [CW-1:0] count_d;
    logic          afull_q;

    assign count_d = CW'(wr_ptr_d - rd_ptr_d) + CW'(rd_pend_d) + CW'(skid_cnt_d);

    always_ff @(posedge clk) begin
        if (rst) afull_q <= 1'b0;
        else     afull_q <= (count_d >= CW'(AFULL_THRESH));
    end

    assign bus.almost_full = afull_q;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM plus a queue scoreboard holding every accepted word.
module tb_ram_fifo_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef RAM_FIFO_AFULL_EN
    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(14)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`else
    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    // dual_port_ram stand-in: registered read on port 2
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] dout_q = '0;
    always @(posedge clk) begin
        if (bus.ram_we1) mem[bus.ram_addr1] <= bus.ram_din1;
        if (!bus.ram_we2) dout_q <= mem[bus.ram_addr2];
    end
    assign bus.ram_dout2 = dout_q;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] q [$];
    int wr_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, score the handshakes, check fill level after the edge
    task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr,
                        output logic pushed, output logic popped);
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        #1;
        pushed = bus.s_valid && bus.s_ready;
        popped = bus.m_valid && bus.m_ready;
        if (bus.m_valid && q.size() == 0) check("m_valid_spurious", 32'(bus.m_valid), 32'd0);
        if (popped && q.size() != 0) begin
            check("m_data_order", 32'(bus.m_data), 32'(q[0]));
            void'(q.pop_front());
        end
        check("we1", 32'(bus.ram_we1), 32'(pushed));
        if (pushed) begin
            check("wr_addr", 32'(bus.ram_addr1), 32'(wr_cnt % DEPTH));
            check("wr_din", 32'(bus.ram_din1), 32'(sd));
            q.push_back(sd);
            wr_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        check("count", 32'(bus.count), 32'(q.size()));
`ifdef RAM_FIFO_AFULL_EN
        check("almost_full", 32'(bus.almost_full), 32'(q.size() >= 14));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        wr_cnt = 0;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);
        check("rst_we1", 32'(bus.ram_we1), 32'd0);
        check("rst_we2", 32'(bus.ram_we2), 32'd0);
`ifdef RAM_FIFO_AFULL_EN
        check("rst_almost_full", 32'(bus.almost_full), 32'd0);
`endif
    endtask

    task automatic drain(input int budget);
        logic p, o;
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            step(1'b0, '0, 1'b1, p, o);
            n++;
        end
        check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic p, o;
        logic [DW-1:0] nxt;
        int pushed_n, cyc;

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst_m_data", 32'(bus.m_data), 32'd0);

        // Single word latency
        step(1'b1, 8'hA5, 1'b1, p, o);
        check("lat_accept", 32'(p), 32'd1);
        check("lat_mv_c1", 32'(bus.m_valid), 32'd0);
        step(1'b0, '0, 1'b1, p, o);
        check("lat_mv_c2", 32'(bus.m_valid), 32'd0);
        step(1'b0, '0, 1'b1, p, o);
        check("lat_mv_c3", 32'(bus.m_valid), 32'd1);
        check("lat_data", 32'(bus.m_data), 32'hA5);
        step(1'b0, '0, 1'b1, p, o);
        check("lat_popped", 32'(o), 32'd1);
        check("lat_empty_hold", 32'(bus.m_data), 32'hA5);

        // Fill to DEPTH+2 with the consumer stalled
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1'b1, DW'(i), 1'b0, p, o);
            check("fill_accept", 32'(p), 32'd1);
        end
        check("full_s_ready", 32'(bus.s_ready), 32'd0);
        check("full_m_valid", 32'(bus.m_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'hEE, 1'b0, p, o);
            check("full_ignore", 32'(p), 32'd0);
        end

        // Full throughput from full
        nxt = 8'h12;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, nxt, 1'b1, p, o);
            check("thru_pop", 32'(o), 32'd1);
            if (i > 0) check("thru_push", 32'(p), 32'd1);
            if (p) nxt++;
        end
        drain(100);

        // Random traffic, wraps the pointers several times
        do_reset();
        pushed_n = 0;
        cyc = 0;
        while ((pushed_n < 100 || q.size() != 0) && cyc < 3000) begin
            step((pushed_n < 100) && ($urandom_range(0, 3) != 0), DW'($urandom),
                 $urandom_range(0, 2) != 0, p, o);
            if (p) pushed_n++;
            cyc++;
        end
        check("rand_pushed", 32'(pushed_n), 32'd100);
        check("rand_drained", 32'(q.size()), 32'd0);

        // Reset while a RAM read is in flight
        do_reset();
        step(1'b1, 8'h77, 1'b0, p, o);
        step(1'b0, '0, 1'b0, p, o);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        wr_cnt = 0;
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, p, o);
            check("mid_rst_discard", 32'(bus.m_valid), 32'd0);
        end
        step(1'b1, 8'h3C, 1'b1, p, o);
        cyc = 0;
        while (!bus.m_valid && cyc < 10) begin
            step(1'b0, '0, 1'b0, p, o);
            cyc++;
        end
        check("mid_rst_first", 32'(bus.m_data), 32'h3C);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
